// File: rtl/weight_load_writer.sv
// Load-side feeder for the memory pool's weight and bias groups: converts a
// bank-wide DMA stream into registered bias writes followed by weight writes.
module weight_load_writer #(
  parameter int CHL_PARA        = 8,
  parameter int BANK_UNIT_WIDTH = 8,
  parameter int WEIT_ADDR_WIDTH = 12,
  parameter int BIAS_ADDR_WIDTH = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_p,
  input  logic                                         cmd_valid_i,
  output logic                                         cmd_ready_o,
  input  logic [WEIT_ADDR_WIDTH-1:0]                   cmd_weit_base_i,
  input  logic [WEIT_ADDR_WIDTH:0]                     cmd_weit_rows_i,
  input  logic [BIAS_ADDR_WIDTH-1:0]                   cmd_bias_base_i,
  input  logic [BIAS_ADDR_WIDTH:0]                     cmd_bias_rows_i,
  input  logic                                         data_valid_i,
  input  logic [BANK_UNIT_WIDTH*CHL_PARA-1:0]          data_i,
  output logic                                         data_ready_o,
  output logic                                         weight_write_en_o,
  output logic [CHL_PARA-1:0]                          weight_write_bank_o,
  output logic [WEIT_ADDR_WIDTH-1:0]                   weight_write_addr_o,
  output logic [CHL_PARA*CHL_PARA*BANK_UNIT_WIDTH-1:0] weight_write_data_o,
  output logic                                         bias_write_en_o,
  output logic                                         bias_write_bank_o,
  output logic [BIAS_ADDR_WIDTH-1:0]                   bias_write_addr_o,
  output logic [CHL_PARA*BANK_UNIT_WIDTH-1:0]          bias_write_data_o,
  output logic                                         busy_o,
  output logic                                         done_o
);

  localparam int BANK_IDX_W = (CHL_PARA > 1) ? $clog2(CHL_PARA) : 1;
  localparam logic [BANK_IDX_W-1:0]    LAST_BANK = BANK_IDX_W'(CHL_PARA - 1);
  localparam logic [WEIT_ADDR_WIDTH:0] WEIT_ONE  = (WEIT_ADDR_WIDTH + 1)'(1);
  localparam logic [BIAS_ADDR_WIDTH:0] BIAS_ONE  = (BIAS_ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, BIAS, WEIT, DONE} state_t;

  state_t                     state;
  logic [WEIT_ADDR_WIDTH-1:0] weit_addr;
  logic [WEIT_ADDR_WIDTH:0]   weit_left;
  logic [BIAS_ADDR_WIDTH-1:0] bias_addr;
  logic [BIAS_ADDR_WIDTH:0]   bias_left;
  logic [BANK_IDX_W-1:0]      bank_idx;
  logic [CHL_PARA-1:0]        bank_onehot;

  assign bank_onehot = CHL_PARA'(1) << bank_idx;

  // Handshake flags are set on the transition into each state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state               <= IDLE;
      cmd_ready_o         <= 1'b1;
      data_ready_o        <= 1'b0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      weit_addr           <= '0;
      weit_left           <= '0;
      bias_addr           <= '0;
      bias_left           <= '0;
      bank_idx            <= '0;
      weight_write_en_o   <= 1'b0;
      weight_write_bank_o <= '0;
      weight_write_addr_o <= '0;
      weight_write_data_o <= '0;
      bias_write_en_o     <= 1'b0;
      bias_write_bank_o   <= 1'b0;
      bias_write_addr_o   <= '0;
      bias_write_data_o   <= '0;
    end else begin
      weight_write_en_o   <= 1'b0;
      weight_write_bank_o <= '0;
      bias_write_en_o     <= 1'b0;
      bias_write_bank_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            weit_addr   <= cmd_weit_base_i;
            weit_left   <= cmd_weit_rows_i;
            bias_addr   <= cmd_bias_base_i;
            bias_left   <= cmd_bias_rows_i;
            bank_idx    <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (cmd_bias_rows_i != '0) begin
              state        <= BIAS;
              data_ready_o <= 1'b1;
            end else if (cmd_weit_rows_i != '0) begin
              state        <= WEIT;
              data_ready_o <= 1'b1;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        BIAS: begin
          if (data_valid_i) begin
            bias_write_en_o   <= 1'b1;
            bias_write_bank_o <= 1'b1;
            bias_write_addr_o <= bias_addr;
            bias_write_data_o <= data_i;
            bias_addr         <= bias_addr + BIAS_ADDR_WIDTH'(1);
            bias_left         <= bias_left - BIAS_ONE;
            if (bias_left == BIAS_ONE) begin
              if (weit_left != '0) begin
                state <= WEIT;
              end else begin
                state        <= DONE;
                data_ready_o <= 1'b0;
                done_o       <= 1'b1;
              end
            end
          end
        end
        WEIT: begin
          if (data_valid_i) begin
            weight_write_en_o   <= 1'b1;
            weight_write_bank_o <= bank_onehot;
            weight_write_addr_o <= weit_addr;
            weight_write_data_o <= {CHL_PARA{data_i}};
            // A weight row spans one beat per bank; the address only advances after the last bank.
            if (bank_idx == LAST_BANK) begin
              bank_idx  <= '0;
              weit_addr <= weit_addr + WEIT_ADDR_WIDTH'(1);
              weit_left <= weit_left - WEIT_ONE;
              if (weit_left == WEIT_ONE) begin
                state        <= DONE;
                data_ready_o <= 1'b0;
                done_o       <= 1'b1;
              end
            end else begin
              bank_idx <= bank_idx + BANK_IDX_W'(1);
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          done_o      <= 1'b0;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          cmd_ready_o  <= 1'b1;
          data_ready_o <= 1'b0;
          busy_o       <= 1'b0;
          done_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_writer.sv
// Bench for weight_load_writer: a write-list model built from each command is
// compared against the DUT every cycle, plus literal checks per directed test.
module tb_weight_load_writer;

  localparam int CHL_PARA        = 8;
  localparam int BANK_UNIT_WIDTH = 8;
  localparam int WEIT_ADDR_WIDTH = 12;
  localparam int BIAS_ADDR_WIDTH = 8;
  localparam int ROW_W           = CHL_PARA * BANK_UNIT_WIDTH;
  localparam logic [ROW_W-1:0] STEP = 64'h0102030405060708;

  logic                                         clk = 1'b0;
  logic                                         rst_p;
  logic                                         cmd_valid_i;
  logic                                         cmd_ready_o;
  logic [WEIT_ADDR_WIDTH-1:0]                   cmd_weit_base_i;
  logic [WEIT_ADDR_WIDTH:0]                     cmd_weit_rows_i;
  logic [BIAS_ADDR_WIDTH-1:0]                   cmd_bias_base_i;
  logic [BIAS_ADDR_WIDTH:0]                     cmd_bias_rows_i;
  logic                                         data_valid_i;
  logic [ROW_W-1:0]                             data_i;
  logic                                         data_ready_o;
  logic                                         weight_write_en_o;
  logic [CHL_PARA-1:0]                          weight_write_bank_o;
  logic [WEIT_ADDR_WIDTH-1:0]                   weight_write_addr_o;
  logic [CHL_PARA*CHL_PARA*BANK_UNIT_WIDTH-1:0] weight_write_data_o;
  logic                                         bias_write_en_o;
  logic                                         bias_write_bank_o;
  logic [BIAS_ADDR_WIDTH-1:0]                   bias_write_addr_o;
  logic [ROW_W-1:0]                             bias_write_data_o;
  logic                                         busy_o;
  logic                                         done_o;

  weight_load_writer #(
    .CHL_PARA(CHL_PARA), .BANK_UNIT_WIDTH(BANK_UNIT_WIDTH),
    .WEIT_ADDR_WIDTH(WEIT_ADDR_WIDTH), .BIAS_ADDR_WIDTH(BIAS_ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst_p(rst_p),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_weit_base_i(cmd_weit_base_i), .cmd_weit_rows_i(cmd_weit_rows_i),
    .cmd_bias_base_i(cmd_bias_base_i), .cmd_bias_rows_i(cmd_bias_rows_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .weight_write_en_o(weight_write_en_o), .weight_write_bank_o(weight_write_bank_o),
    .weight_write_addr_o(weight_write_addr_o), .weight_write_data_o(weight_write_data_o),
    .bias_write_en_o(bias_write_en_o), .bias_write_bank_o(bias_write_bank_o),
    .bias_write_addr_o(bias_write_addr_o), .bias_write_data_o(bias_write_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_weit;
    logic [7:0]  bank;
    logic [11:0] addr;
  } wr_t;

  typedef struct {
    logic         is_weit;
    logic [7:0]   bank;
    logic [11:0]  addr;
    logic [511:0] data;
    int           cyc;
  } log_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc;
  logic [ROW_W-1:0] data_base;

  wr_t  plan[$];
  log_t wlog[$];
  int   done_log[$];
  bit   m_valid = 1'b0;
  int   m_phase = 0;
  int   m_cmds = 0;
  int   m_beats = 0;
  bit   m_clean = 1'b0;
  bit   exp_wr = 1'b0;
  wr_t  exp_desc;
  logic [ROW_W-1:0] exp_data;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // The whole write list of a command: bias rows first, then each weight row once per bank.
  task automatic build_plan(input logic [11:0] wb, input logic [12:0] wr,
                            input logic [7:0] bb, input logic [8:0] br);
    wr_t w;
    plan.delete();
    for (int k = 0; k < int'(br); k++) begin
      w.is_weit = 1'b0;
      w.bank    = 8'h01;
      w.addr    = 12'(8'(int'(bb) + k));
      plan.push_back(w);
    end
    for (int r = 0; r < int'(wr); r++) begin
      for (int b = 0; b < CHL_PARA; b++) begin
        w.is_weit = 1'b1;
        w.bank    = 8'(1 << b);
        w.addr    = 12'(int'(wb) + r);
        plan.push_back(w);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_p) begin
      m_valid = 1'b1;
      m_phase = 0;
      exp_wr  = 1'b0;
      m_clean = 1'b1;
      m_beats = 0;
      plan.delete();
    end else if (m_valid) begin
      exp_wr = 1'b0;
      case (m_phase)
        0: if (cmd_valid_i) begin
          build_plan(cmd_weit_base_i, cmd_weit_rows_i, cmd_bias_base_i, cmd_bias_rows_i);
          m_cmds++;
          m_beats = 0;
          m_phase = (plan.size() == 0) ? 2 : 1;
        end
        1: if (data_valid_i) begin
          exp_desc = plan.pop_front();
          exp_data = data_i;
          exp_wr   = 1'b1;
          m_clean  = 1'b0;
          m_beats++;
          if (plan.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0]  exp_ctrl;
    logic [10:0] exp_strb;
    if (m_valid) begin
      exp_ctrl = {m_phase == 0, m_phase == 1, m_phase != 0, m_phase == 2};
      checkOutput("ctrl", 512'({cmd_ready_o, data_ready_o, busy_o, done_o}), 512'(exp_ctrl));
      exp_strb = {exp_wr & exp_desc.is_weit, exp_wr & ~exp_desc.is_weit, exp_wr & ~exp_desc.is_weit,
                  (exp_wr & exp_desc.is_weit) ? exp_desc.bank : 8'h00};
      checkOutput("strobes", 512'({weight_write_en_o, bias_write_en_o, bias_write_bank_o, weight_write_bank_o}),
                  512'(exp_strb));
      if (exp_wr && exp_desc.is_weit) begin
        checkOutput("weight_addr", 512'(weight_write_addr_o), 512'(exp_desc.addr));
        checkOutput("weight_data", weight_write_data_o, {CHL_PARA{exp_data}});
      end else if (exp_wr) begin
        checkOutput("bias_addr", 512'(bias_write_addr_o), 512'(exp_desc.addr[7:0]));
        checkOutput("bias_data", 512'(bias_write_data_o), 512'(exp_data));
      end
      if (m_clean) begin
        checkOutput("reset_addr_data",
                    512'({weight_write_addr_o, bias_write_addr_o, bias_write_data_o}) | weight_write_data_o, 512'(0));
      end
    end
    if (weight_write_en_o === 1'b1)
      wlog.push_back('{1'b1, weight_write_bank_o, weight_write_addr_o, weight_write_data_o, cyc});
    if (bias_write_en_o === 1'b1)
      wlog.push_back('{1'b0, 8'(bias_write_bank_o), 12'(bias_write_addr_o), 512'(bias_write_data_o), cyc});
    if (done_o === 1'b1) done_log.push_back(cyc);
  end

  // Issues one command and streams beats until the model is idle again; optional
  // reset after a given beat count, optional second (empty) command held pending.
  task automatic applyStimulus(input logic [11:0] wb, input logic [12:0] wr,
                               input logic [7:0] bb, input logic [8:0] br,
                               input bit gaps, input int abort_at, input bit hold_next);
    int  start_cmds;
    int  want;
    int  n;
    bit  finished;
    start_cmds = m_cmds;
    want       = start_cmds + (hold_next ? 2 : 1);
    finished   = 1'b0;
    acc_cyc    = -1;
    wlog.delete();
    done_log.delete();
    @(negedge clk);
    cmd_weit_base_i = wb;
    cmd_weit_rows_i = wr;
    cmd_bias_base_i = bb;
    cmd_bias_rows_i = br;
    cmd_valid_i     = 1'b1;
    data_valid_i    = 1'b1;
    data_i          = data_base;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (acc_cyc < 0 && m_cmds != start_cmds) begin
        acc_cyc = cyc - 1;
        if (hold_next) begin
          cmd_weit_rows_i = '0;
          cmd_bias_rows_i = '0;
        end else begin
          cmd_valid_i = 1'b0;
        end
      end
      if (m_cmds == want) cmd_valid_i = 1'b0;
      if (abort_at >= 0 && m_phase == 1 && m_beats == abort_at) begin
        rst_p = 1'b1;
        @(negedge clk);
        rst_p        = 1'b0;
        data_valid_i = 1'b0;
        cmd_valid_i  = 1'b0;
        finished     = 1'b1;
        break;
      end
      if (m_cmds == want && m_phase == 0) begin
        finished = 1'b1;
        break;
      end
      data_valid_i = gaps ? ~data_valid_i : 1'b1;
      data_i       = data_base + 64'(m_beats) * STEP;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: transfer not complete after %0d cycles", n);
    end
    data_valid_i = 1'b0;
    cmd_valid_i  = 1'b0;
  endtask

  initial begin
    rst_p = 1'b1;
    cmd_valid_i = 1'b0; cmd_weit_base_i = '0; cmd_weit_rows_i = '0;
    cmd_bias_base_i = '0; cmd_bias_rows_i = '0;
    data_valid_i = 1'b0; data_i = '0; data_base = 64'h1111_2222_3333_4444;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", 512'({cmd_ready_o, data_ready_o, busy_o, done_o}), 512'(4'b1000));
    rst_p = 1'b0;

    $display("[TB] test 1: bias 2 @0x10, weight 3 @0xFFE, continuous");
    applyStimulus(12'hFFE, 13'd3, 8'h10, 9'd2, 1'b0, -1, 1'b0);
    checkOutput("t1_count", 512'(wlog.size()), 512'(26));
    if (wlog.size() == 26) begin
      checkOutput("t1_bias0", 512'({wlog[0].is_weit, wlog[0].addr}), 512'({1'b0, 12'h010}));
      checkOutput("t1_bias1", 512'({wlog[1].is_weit, wlog[1].addr}), 512'({1'b0, 12'h011}));
      checkOutput("t1_w0", 512'({wlog[2].bank, wlog[2].addr}), 512'({8'h01, 12'hFFE}));
      checkOutput("t1_w7", 512'({wlog[9].bank, wlog[9].addr}), 512'({8'h80, 12'hFFE}));
      checkOutput("t1_w8", 512'({wlog[10].bank, wlog[10].addr}), 512'({8'h01, 12'hFFF}));
      checkOutput("t1_wrap", 512'({wlog[25].bank, wlog[25].addr}), 512'({8'h80, 12'h000}));
      checkOutput("t1_lastdata", 512'(wlog[25].data[63:0]), 512'(64'h1111_2222_3333_4444 + 64'd25 * STEP));
      checkOutput("t1_done_with_last", 512'(done_log.size() == 1 && done_log[0] == wlog[25].cyc), 512'(1));
    end
    checkOutput("t1_done_cycle", 512'(done_log.size() > 0 ? done_log[0] - acc_cyc : -1), 512'(27));

    $display("[TB] test 2: same command, data_valid toggling");
    applyStimulus(12'hFFE, 13'd3, 8'h10, 9'd2, 1'b1, -1, 1'b0);
    checkOutput("t2_count", 512'(wlog.size()), 512'(26));
    checkOutput("t2_done_once", 512'(done_log.size()), 512'(1));
    if (wlog.size() == 26)
      checkOutput("t2_span", 512'(wlog[25].cyc - wlog[0].cyc), 512'(50));

    $display("[TB] test 3: empty command");
    applyStimulus(12'h123, 13'd0, 8'h45, 9'd0, 1'b0, -1, 1'b0);
    checkOutput("t3_no_writes", 512'(wlog.size()), 512'(0));
    checkOutput("t3_done_cycle", 512'(done_log.size() > 0 ? done_log[0] - acc_cyc : -1), 512'(1));

    $display("[TB] test 4: single bias row");
    data_base = 64'h0123456789ABCDEF;
    applyStimulus(12'h000, 13'd0, 8'h7F, 9'd1, 1'b0, -1, 1'b0);
    checkOutput("t4_count", 512'(wlog.size()), 512'(1));
    if (wlog.size() == 1)
      checkOutput("t4_bias", 512'({wlog[0].is_weit, wlog[0].bank, wlog[0].addr, wlog[0].data[63:0]}),
                  512'({1'b0, 8'h01, 12'h07F, 64'h0123456789ABCDEF}));

    $display("[TB] test 5: weight-only row with second command pending");
    data_base = 64'hA5A5A5A5A5A5A5A5;
    applyStimulus(12'h200, 13'd1, 8'h00, 9'd0, 1'b0, -1, 1'b1);
    checkOutput("t5_count", 512'(wlog.size()), 512'(8));
    if (wlog.size() == 8)
      checkOutput("t5_replicated", wlog[0].data, {8{64'hA5A5A5A5A5A5A5A5}});
    if (wlog.size() == 8)
      checkOutput("t5_bank0", 512'({wlog[0].bank, wlog[0].addr}), 512'({8'h01, 12'h200}));
    checkOutput("t5_done_pair", 512'(done_log.size() == 2 ? {done_log[0] - acc_cyc, done_log[1] - done_log[0]} : 64'd0),
                512'({32'd9, 32'd2}));

    $display("[TB] test 6: reset after 5 of 24 weight beats");
    data_base = 64'h0F0F_0000_1234_5678;
    applyStimulus(12'h123, 13'd3, 8'h00, 9'd0, 1'b0, 5, 1'b0);
    checkOutput("t6_reset_ctrl", 512'({cmd_ready_o, data_ready_o, busy_o, done_o, weight_write_en_o,
                                       bias_write_en_o, weight_write_bank_o, weight_write_addr_o}),
                512'({4'b1000, 2'b00, 8'h00, 12'h000}));
    checkOutput("t6_partial", 512'(wlog.size()), 512'(5));
    applyStimulus(12'h040, 13'd1, 8'h00, 9'd0, 1'b0, -1, 1'b0);
    checkOutput("t6_restart_count", 512'(wlog.size()), 512'(8));
    if (wlog.size() == 8)
      checkOutput("t6_restart", 512'({wlog[0].bank, wlog[0].addr, wlog[7].bank}), 512'({8'h01, 12'h040, 8'h80}));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
